// File: rtl/fix_rx_validator.sv
// fix_rx_validator
//   Session-level validator for a FIX receive path. A tag/value parser feeds
//   the header fields (8, 9, 35) and the body fields one at a time. The block
//   checks version, message type, required tags, body length, checksum and
//   sequence number. It then issues one registered result strobe per message.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   session_i            session id, sampled with start_of_message_i
//   start_of_message_i   qualifies the first tag of a message
//   end_of_message_i     qualifies the checksum tag (10)
//   tag_valid_i, tag_i   tag number (binary)
//   val_valid_i, val_i   field value (binary for 9/34/36, ASCII in [7:0] otherwise)
//   body_bytes_i         parser byte count after tag 9, valid with end_of_message_i
//   checksum_validity_i  checksum result, valid with end_of_message_i
//   exp_seq_i            expected incoming sequence number per session
//   new_message_o        one-cycle result strobe
//   error_type_o         result code
//   type_o               decoded message type
//   session_o            session of the result
//   seq_num_o            received MsgSeqNum
//   busy_o               message in progress

`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 32
`endif
`ifndef COUNTER_RANGE
`define COUNTER_RANGE 16
`endif
`ifndef supportedVersion
`define supportedVersion 24'h342E34
`endif

module fix_rx_validator #(
  parameter int VALUE_WIDTH   = `VALUE_DATA_WIDTH,
  parameter int COUNTER_DEPTH = `COUNTER_RANGE,
  parameter int NUM_SESSIONS  = 4,
  localparam int SID_W        = (NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [SID_W-1:0]                  session_i,
  input  logic                              start_of_message_i,
  input  logic                              end_of_message_i,
  input  logic                              tag_valid_i,
  input  logic [31:0]                       tag_i,
  input  logic                              val_valid_i,
  input  logic [VALUE_WIDTH-1:0]            val_i,
  input  logic [COUNTER_DEPTH-1:0]          body_bytes_i,
  input  logic                              checksum_validity_i,
  input  logic [NUM_SESSIONS*COUNTER_DEPTH-1:0] exp_seq_i,
  output logic                              new_message_o,
  output logic [2:0]                        error_type_o,
  output logic [3:0]                        type_o,
  output logic [SID_W-1:0]                  session_o,
  output logic [COUNTER_DEPTH-1:0]          seq_num_o,
  output logic                              busy_o
);

  typedef enum logic [3:0] {
    IDLE, BEGIN_VAL, LEN_TAG, LEN_VAL, TYPE_TAG, TYPE_VAL, BODY, CHECK, REPORT, DRAIN
  } state_t;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_GARBLED  = 3'd1;
  localparam logic [2:0] E_VERSION  = 3'd2;
  localparam logic [2:0] E_MSGTYPE  = 3'd3;
  localparam logic [2:0] E_MISSING  = 3'd4;
  localparam logic [2:0] E_SEQ_LOW  = 3'd5;
  localparam logic [2:0] E_SEQ_HIGH = 3'd6;
  localparam logic [2:0] E_BODYLEN  = 3'd7;

  localparam logic [23:0] SUPPORTED_VER = `supportedVersion;
  localparam logic [7:0]  ASCII_Y       = 8'h59;

  // Type '4' is decoded as reset (4); it becomes gapFill (5) at report time
  // once tag 123 has been seen, because 123 arrives after tag 35.
  function automatic logic [2:0] decode_type(input logic [7:0] c);
    case (c)
      8'h41:   decode_type = 3'd1;
      8'h35:   decode_type = 3'd2;
      8'h30:   decode_type = 3'd3;
      8'h34:   decode_type = 3'd4;
      8'h32:   decode_type = 3'd6;
      8'h31:   decode_type = 3'd7;
      default: decode_type = 3'd0;
    endcase
  endfunction

  state_t                     state_q, state_nx;
  logic [2:0]                 err_q, err_nx;
  logic [SID_W-1:0]           sess_q;
  logic [COUNTER_DEPTH-1:0]   body_len_q;
  logic [COUNTER_DEPTH-1:0]   bytes_q;
  logic [COUNTER_DEPTH-1:0]   seq_q;
  logic [2:0]                 type_q;
  logic [31:0]                pend_tag_q;
  logic                       csum_ok_q;
  logic                       possdup_q, gapfill_q;
  logic                       has34_q, has49_q, has52_q, has56_q;

  logic [COUNTER_DEPTH-1:0]   exp_arr [NUM_SESSIONS];
  logic [COUNTER_DEPTH-1:0]   exp_cur;
  logic [31:0]                body_key;
  logic                       pre_body;
  logic                       is_seqreset;
  logic [2:0]                 check_err;
  logic [3:0]                 rpt_type;
  logic                       unused_val;

  assign unused_val = ^val_i;

  always_comb begin
    for (int s = 0; s < NUM_SESSIONS; s++) begin
      exp_arr[s] = exp_seq_i[s*COUNTER_DEPTH +: COUNTER_DEPTH];
    end
  end

  assign exp_cur     = exp_arr[sess_q];
  // A value may share its cycle with its tag, otherwise it belongs to the last tag.
  assign body_key    = tag_valid_i ? tag_i : pend_tag_q;
  assign pre_body    = (state_q == BEGIN_VAL) || (state_q == LEN_TAG) || (state_q == LEN_VAL) ||
                       (state_q == TYPE_TAG)  || (state_q == TYPE_VAL);
  // SequenceReset (with or without GapFill) is exempt from both sequence checks.
  assign is_seqreset = (type_q == 3'd4);
  assign rpt_type    = (is_seqreset && gapfill_q) ? 4'd5 : {1'b0, type_q};

  always_comb begin
    check_err = E_NONE;
    if (!csum_ok_q)                                      check_err = E_GARBLED;
    else if (bytes_q != body_len_q)                      check_err = E_BODYLEN;
    else if (!(has34_q && has49_q && has52_q && has56_q)) check_err = E_MISSING;
    else if ((seq_q < exp_cur) && !(possdup_q || is_seqreset)) check_err = E_SEQ_LOW;
    else if ((seq_q > exp_cur) && !is_seqreset)           check_err = E_SEQ_HIGH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= E_NONE;
    end else begin
      state_q <= state_nx;
      err_q   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    err_nx   = err_q;
    case (state_q)
      IDLE: begin
        if (start_of_message_i && tag_valid_i) begin
          err_nx = E_NONE;
          if (end_of_message_i) begin
            err_nx   = E_GARBLED;
            state_nx = REPORT;
          end else if (tag_i == 32'd8) begin
            state_nx = BEGIN_VAL;
          end else begin
            err_nx   = E_GARBLED;
            state_nx = DRAIN;
          end
        end
      end
      BEGIN_VAL: begin
        if (val_valid_i) begin
          if (val_i[23:0] > SUPPORTED_VER) begin
            err_nx   = E_VERSION;
            state_nx = DRAIN;
          end else begin
            state_nx = LEN_TAG;
          end
        end
      end
      LEN_TAG: begin
        if (tag_valid_i) begin
          if (tag_i == 32'd9) state_nx = LEN_VAL;
          else begin
            err_nx   = E_GARBLED;
            state_nx = DRAIN;
          end
        end
      end
      LEN_VAL: begin
        if (val_valid_i) state_nx = TYPE_TAG;
      end
      TYPE_TAG: begin
        if (tag_valid_i) begin
          if (tag_i == 32'd35) state_nx = TYPE_VAL;
          else begin
            err_nx   = E_GARBLED;
            state_nx = DRAIN;
          end
        end
      end
      TYPE_VAL: begin
        if (val_valid_i) begin
          if (decode_type(val_i[7:0]) == 3'd0) begin
            err_nx   = E_MSGTYPE;
            state_nx = DRAIN;
          end else begin
            state_nx = BODY;
          end
        end
      end
      BODY: begin
        if (end_of_message_i) state_nx = CHECK;
      end
      CHECK: begin
        err_nx   = check_err;
        state_nx = REPORT;
      end
      REPORT: begin
        state_nx = IDLE;
      end
      DRAIN: begin
        if (end_of_message_i) state_nx = REPORT;
      end
      default: begin
        err_nx   = E_GARBLED;
        state_nx = IDLE;
      end
    endcase

    if (pre_body && end_of_message_i) begin
      err_nx   = E_GARBLED;
      state_nx = REPORT;
    end

    // A new start while a message is open closes the old one as garbled; the
    // new message itself is dropped and must be resent by the parser.
    if (start_of_message_i && (state_q != IDLE) && (state_q != REPORT)) begin
      err_nx   = E_GARBLED;
      state_nx = REPORT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sess_q     <= '0;
      body_len_q <= '0;
      bytes_q    <= '0;
      seq_q      <= '0;
      type_q     <= '0;
      pend_tag_q <= '0;
      csum_ok_q  <= 1'b0;
      possdup_q  <= 1'b0;
      gapfill_q  <= 1'b0;
      has34_q    <= 1'b0;
      has49_q    <= 1'b0;
      has52_q    <= 1'b0;
      has56_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_of_message_i && tag_valid_i) begin
            sess_q     <= session_i;
            body_len_q <= '0;
            bytes_q    <= '0;
            seq_q      <= '0;
            type_q     <= '0;
            pend_tag_q <= '0;
            csum_ok_q  <= 1'b0;
            possdup_q  <= 1'b0;
            gapfill_q  <= 1'b0;
            has34_q    <= 1'b0;
            has49_q    <= 1'b0;
            has52_q    <= 1'b0;
            has56_q    <= 1'b0;
          end
        end
        LEN_VAL: begin
          if (val_valid_i) body_len_q <= val_i[COUNTER_DEPTH-1:0];
        end
        TYPE_VAL: begin
          if (val_valid_i) type_q <= decode_type(val_i[7:0]);
        end
        BODY: begin
          if (tag_valid_i) pend_tag_q <= tag_i;
          if (val_valid_i) begin
            case (body_key)
              32'd34: begin
                seq_q   <= val_i[COUNTER_DEPTH-1:0];
                has34_q <= 1'b1;
              end
              32'd43:  possdup_q <= (val_i[7:0] == ASCII_Y);
              32'd49:  has49_q   <= 1'b1;
              32'd52:  has52_q   <= 1'b1;
              32'd56:  has56_q   <= 1'b1;
              32'd123: gapfill_q <= (val_i[7:0] == ASCII_Y);
              default: ;
            endcase
          end
          if (end_of_message_i) begin
            csum_ok_q <= checksum_validity_i;
            bytes_q   <= body_bytes_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers are loaded on entry to REPORT so the strobe and its
  // fields appear together for the single REPORT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_message_o <= 1'b0;
      error_type_o  <= '0;
      type_o        <= '0;
      session_o     <= '0;
      seq_num_o     <= '0;
      busy_o        <= 1'b0;
    end else begin
      new_message_o <= (state_nx == REPORT);
      busy_o        <= (state_nx != IDLE);
      if (state_nx == REPORT) begin
        error_type_o <= err_nx;
        if (state_q == IDLE) begin
          // Start and end in the same cycle: nothing of this message is latched yet.
          type_o    <= '0;
          session_o <= session_i;
          seq_num_o <= '0;
        end else begin
          type_o    <= rpt_type;
          session_o <= sess_q;
          seq_num_o <= seq_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_fix_rx_validator.sv
module tb_fix_rx_validator;

  localparam int VW = 32;
  localparam int CD = 16;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam logic [15:0] LEN    = 16'd100;
  localparam logic [31:0] VER_OK = 32'h00342E34;
  localparam logic [31:0] VER_HI = 32'h00352E30;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [SW-1:0]  session_i;
  logic           start_of_message_i, end_of_message_i;
  logic           tag_valid_i, val_valid_i;
  logic [31:0]    tag_i;
  logic [VW-1:0]  val_i;
  logic [CD-1:0]  body_bytes_i;
  logic           checksum_validity_i;
  logic [NS*CD-1:0] exp_seq_i;
  logic           new_message_o;
  logic [2:0]     error_type_o;
  logic [3:0]     type_o;
  logic [SW-1:0]  session_o;
  logic [CD-1:0]  seq_num_o;
  logic           busy_o;

  fix_rx_validator #(.VALUE_WIDTH(VW), .COUNTER_DEPTH(CD), .NUM_SESSIONS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .session_i(session_i),
    .start_of_message_i(start_of_message_i), .end_of_message_i(end_of_message_i),
    .tag_valid_i(tag_valid_i), .tag_i(tag_i), .val_valid_i(val_valid_i), .val_i(val_i),
    .body_bytes_i(body_bytes_i), .checksum_validity_i(checksum_validity_i),
    .exp_seq_i(exp_seq_i), .new_message_o(new_message_o), .error_type_o(error_type_o),
    .type_o(type_o), .session_o(session_o), .seq_num_o(seq_num_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]    err;
    logic [3:0]    typ;
    logic [SW-1:0] sess;
    logic [CD-1:0] seq;
    int            at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (new_message_o !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_strobe: got strobe=%b at cycle %0d, expected none", new_message_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("error_type", 32'(error_type_o), 32'(e.err));
        chk("type",       32'(type_o),       32'(e.typ));
        chk("session",    32'(session_o),    32'(e.sess));
        chk("seq_num",    32'(seq_num_o),    32'(e.seq));
        chk("strobe_cycle", 32'(cyc),        32'(e.at));
      end
    end
  end

  task automatic expect_rpt(input logic [2:0] err, input logic [3:0] typ,
                            input logic [SW-1:0] s, input logic [CD-1:0] seq, input int lat);
    exp_t e;
    e.err = err; e.typ = typ; e.sess = s; e.seq = seq; e.at = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic put_tag(input logic [31:0] t);
    tag_valid_i = 1'b1; tag_i = t;
    step();
    tag_valid_i = 1'b0;
  endtask

  task automatic put_val(input logic [31:0] v);
    val_valid_i = 1'b1; val_i = v;
    step();
    val_valid_i = 1'b0;
  endtask

  task automatic field(input logic [31:0] t, input logic [31:0] v);
    put_tag(t);
    put_val(v);
  endtask

  task automatic put_som(input logic [31:0] t, input logic [SW-1:0] s);
    start_of_message_i = 1'b1; session_i = s;
    put_tag(t);
    start_of_message_i = 1'b0;
  endtask

  // Checksum tag; afterwards wait until the block is idle again.
  task automatic put_eom(input logic [CD-1:0] bytes, input logic csum);
    end_of_message_i = 1'b1; body_bytes_i = bytes; checksum_validity_i = csum;
    put_tag(32'd10);
    end_of_message_i = 1'b0;
    step();
    step();
  endtask

  task automatic hdr(input logic [SW-1:0] s, input logic [7:0] tch);
    put_som(32'd8, s);
    put_val(VER_OK);
    field(32'd9, 32'(LEN));
    field(32'd35, 32'(tch));
  endtask

  // opt43: 0 absent, 1 'N', 2 'Y'
  task automatic full_msg(input logic [SW-1:0] s, input logic [7:0] tch, input logic [CD-1:0] seq,
                          input int opt43, input bit with56, input bit gf, input int dbytes,
                          input bit csum, input logic [2:0] xe, input logic [3:0] xt);
    hdr(s, tch);
    field(32'd34, 32'(seq));
    if (opt43 != 0) field(32'd43, (opt43 == 2) ? 32'h59 : 32'h4E);
    field(32'd49, 32'h53);
    field(32'd52, 32'd1234);
    if (with56) field(32'd56, 32'h54);
    if (gf) field(32'd123, 32'h59);
    expect_rpt(xe, xt, s, seq, 2);
    put_eom(LEN + 16'(dbytes), csum);
  endtask

  logic [7:0] tch_tab [3] = '{8'h35, 8'h32, 8'h31};
  logic [3:0] typ_tab [3] = '{4'd2, 4'd6, 4'd7};

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected $finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    session_i = '0; start_of_message_i = 1'b0; end_of_message_i = 1'b0;
    tag_valid_i = 1'b0; tag_i = '0; val_valid_i = 1'b0; val_i = '0;
    body_bytes_i = '0; checksum_validity_i = 1'b0;
    exp_seq_i = '0;
    exp_seq_i[0*CD +: CD] = 16'd1;
    exp_seq_i[1*CD +: CD] = 16'd9;
    exp_seq_i[2*CD +: CD] = 16'd7;
    exp_seq_i[3*CD +: CD] = 16'd0;
    #1;
    chk("reset_strobe", 32'(new_message_o), 0);
    chk("reset_busy",   32'(busy_o), 0);
    chk("reset_error",  32'(error_type_o), 0);
    chk("reset_type",   32'(type_o), 0);
    chk("reset_session",32'(session_o), 0);
    chk("reset_seq",    32'(seq_num_o), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Main function
    full_msg(2, 8'h41, 16'd7, 0, 1, 0, 0, 1, 3'd0, 4'd1);   // logon, in sequence
    full_msg(2, 8'h41, 16'd5, 0, 1, 0, 0, 1, 3'd5, 4'd1);   // seq low
    full_msg(2, 8'h41, 16'd5, 2, 1, 0, 0, 1, 3'd0, 4'd1);   // seq low, PossDup=Y
    full_msg(2, 8'h41, 16'd5, 1, 1, 0, 0, 1, 3'd5, 4'd1);   // seq low, PossDup=N
    full_msg(2, 8'h41, 16'd9, 0, 1, 0, 0, 1, 3'd6, 4'd1);   // seq high
    full_msg(1, 8'h34, 16'd3, 0, 1, 1, 0, 1, 3'd0, 4'd5);   // gapFill, seq low exempt
    full_msg(1, 8'h34, 16'd12, 0, 1, 0, 0, 1, 3'd0, 4'd4);  // reset, seq high exempt
    full_msg(2, 8'h41, 16'd7, 0, 0, 0, 0, 1, 3'd4, 4'd1);   // tag 56 missing
    full_msg(2, 8'h41, 16'd7, 0, 1, 0, 1, 1, 3'd7, 4'd1);   // body length + 1
    full_msg(2, 8'h41, 16'd7, 0, 1, 0, 1, 0, 3'd1, 4'd1);   // checksum bad wins
    full_msg(2, 8'h41, 16'd5, 0, 0, 0, 0, 1, 3'd4, 4'd1);   // missing beats seq low
    full_msg(0, 8'h30, 16'd1, 0, 1, 0, 0, 1, 3'd0, 4'd3);   // heartbeat
    for (int i = 0; i < 3; i++)
      full_msg(3, tch_tab[i], 16'd0, 0, 1, 0, 0, 1, 3'd0, typ_tab[i]);

    // Repeated tag 34: last value wins
    hdr(2, 8'h41);
    field(32'd34, 32'd3);
    field(32'd34, 32'd7);
    field(32'd49, 32'h53); field(32'd52, 32'd1); field(32'd56, 32'h54);
    expect_rpt(3'd0, 4'd1, 2, 16'd7, 2);
    put_eom(LEN, 1'b1);

    // First tag 9: garbled, reported only after end of message; drained tags ignored
    put_som(32'd9, 3);
    field(32'd8, VER_OK);
    field(32'd34, 32'd55);
    step();
    chk("drain_no_early_strobe_busy", 32'(busy_o), 1);
    expect_rpt(3'd1, 4'd0, 3, 16'd0, 1);
    put_eom(LEN, 1'b1);

    // Unsupported version
    put_som(32'd8, 1);
    put_val(VER_HI);
    field(32'd9, 32'(LEN));
    expect_rpt(3'd2, 4'd0, 1, 16'd0, 1);
    put_eom(LEN, 1'b1);

    // Invalid message type
    hdr(0, 8'h5A);
    field(32'd34, 32'd7);
    expect_rpt(3'd3, 4'd0, 0, 16'd0, 1);
    put_eom(LEN, 1'b1);

    // End of message before body
    put_som(32'd8, 2);
    put_val(VER_OK);
    expect_rpt(3'd1, 4'd0, 2, 16'd0, 1);
    put_eom(LEN, 1'b1);

    // New start inside body aborts old message; new message is discarded
    hdr(1, 8'h30);
    field(32'd34, 32'd3);
    expect_rpt(3'd1, 4'd3, 1, 16'd3, 1);
    put_som(32'd8, 2);
    put_val(VER_OK);
    field(32'd9, 32'(LEN));
    field(32'd35, 32'h41);
    field(32'd34, 32'd7);
    put_eom(LEN, 1'b1);
    chk("idle_after_abort_busy", 32'(busy_o), 0);

    // Report something non-zero so the reset clear is visible
    full_msg(2, 8'h41, 16'd9, 0, 1, 0, 0, 1, 3'd6, 4'd1);

    // Asynchronous reset in the body
    hdr(2, 8'h41);
    field(32'd34, 32'd7);
    chk("busy_in_body", 32'(busy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_strobe",  32'(new_message_o), 0);
    chk("midrst_busy",    32'(busy_o), 0);
    chk("midrst_error",   32'(error_type_o), 0);
    chk("midrst_type",    32'(type_o), 0);
    chk("midrst_session", 32'(session_o), 0);
    chk("midrst_seq",     32'(seq_num_o), 0);
    step();
    rst_n = 1'b1;
    field(32'd49, 32'h53);
    put_eom(LEN, 1'b1);
    chk("post_rst_busy", 32'(busy_o), 0);

    full_msg(2, 8'h41, 16'd7, 0, 1, 0, 0, 1, 3'd0, 4'd1);

    repeat (5) step();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
